// File: rtl/pid_pipe_ctrl.sv
// rtl/pid_pipe_ctrl.sv - three-stage PID pipeline with soft-start output scaling
module pid_pipe_ctrl #(
  parameter int PW      = 16,
  parameter int ERR_W   = 10,
  parameter int OUT_W   = 12,
  parameter int INT_W   = 18,
  parameter int P_COEFF = 9,
  parameter int D_SHIFT = 6,
  parameter int I_SHIFT = 1,
  parameter int SS_INC  = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vld,
  input  logic signed [PW-1:0]    ptch,
  input  logic signed [PW-1:0]    ptch_rt,
  input  logic                    pwr_up,
  input  logic                    rider_off,
  output logic signed [OUT_W-1:0] PID_cntrl,
  output logic                    out_vld,
  output logic [7:0]              ss_tmr,
  output logic [1:0]              ss_state
);

  localparam int TW    = ERR_W + 5;
  localparam int SUM_W = TW + 2;

  localparam logic signed [PW-1:0]    ERR_MAX = PW'((1 << (ERR_W - 1)) - 1);
  localparam logic signed [PW-1:0]    ERR_MIN = PW'(-(1 << (ERR_W - 1)));
  localparam logic signed [INT_W-1:0] I_MAX   = INT_W'((1 << (TW - 1)) - 1);
  localparam logic signed [INT_W-1:0] I_MIN   = INT_W'(-(1 << (TW - 1)));
  localparam logic signed [SUM_W-1:0] O_MAX   = SUM_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] O_MIN   = SUM_W'(-(1 << (OUT_W - 1)));
  localparam logic signed [TW-1:0]    P_K     = TW'(P_COEFF);
  localparam logic [26:0]             SS_STEP = 27'(SS_INC);

  typedef enum logic [1:0] {OFF = 2'd0, RAMP_UP = 2'd1, ON = 2'd2, RAMP_DN = 2'd3} ss_st_t;

  logic signed [ERR_W-1:0]        err_sat;
  logic signed [TW-1:0]           p_term, d_term, i_term;
  logic signed [PW-D_SHIFT-1:0]   rt_hi;
  logic signed [INT_W-1:0]        integ, int_add, int_sum, int_shr;
  logic                           int_ovf;
  logic signed [TW-1:0]           s1_p, s1_d, s1_i;
  logic                           s1_vld;
  logic signed [SUM_W-1:0]        sum_full;
  logic signed [OUT_W-1:0]        sum_sat, s2_sum;
  logic                           s2_vld;
  logic signed [OUT_W+8:0]        prod;
  logic [26:0]                    cnt;
  logic [27:0]                    cnt_up;
  ss_st_t                         state;
  logic                           unused_bits;

  always_comb begin
    err_sat = ptch[ERR_W-1:0];
    if (ptch > ERR_MAX)
      err_sat = ERR_MAX[ERR_W-1:0];
    else if (ptch < ERR_MIN)
      err_sat = ERR_MIN[ERR_W-1:0];
  end

  assign p_term = TW'(err_sat) * P_K;
  assign rt_hi  = ptch_rt[PW-1:D_SHIFT];
  // Widen before negating so the most negative rate still flips cleanly.
  assign d_term = -(TW'(rt_hi));

  assign int_add = INT_W'(err_sat);
  assign int_sum = integ + int_add;
  assign int_ovf = (integ[INT_W-1] == int_add[INT_W-1]) && (int_sum[INT_W-1] != integ[INT_W-1]);
  assign int_shr = integ >>> I_SHIFT;

  always_comb begin
    i_term = int_shr[TW-1:0];
    if (int_shr > I_MAX)
      i_term = I_MAX[TW-1:0];
    else if (int_shr < I_MIN)
      i_term = I_MIN[TW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      integ <= '0;
    else if (rider_off)
      integ <= '0;
    else if (vld && !int_ovf)
      integ <= int_sum;
  end

  // Stage 1: capture terms; I term reflects the integrator before this sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_p   <= '0;
      s1_d   <= '0;
      s1_i   <= '0;
    end else begin
      s1_vld <= vld;
      if (vld) begin
        s1_p <= p_term;
        s1_d <= d_term;
        s1_i <= i_term;
      end
    end
  end

  assign sum_full = SUM_W'(s1_p) + SUM_W'(s1_d) + SUM_W'(s1_i);

  always_comb begin
    sum_sat = sum_full[OUT_W-1:0];
    if (sum_full > O_MAX)
      sum_sat = O_MAX[OUT_W-1:0];
    else if (sum_full < O_MIN)
      sum_sat = O_MIN[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld <= 1'b0;
      s2_sum <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld)
        s2_sum <= sum_sat;
    end
  end

  assign prod = s2_sum * $signed({1'b0, ss_tmr});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld   <= 1'b0;
      PID_cntrl <= '0;
    end else begin
      out_vld <= s2_vld;
      if (s2_vld)
        PID_cntrl <= prod[OUT_W+7:8];
    end
  end

  assign cnt_up = {1'b0, cnt} + 28'(SS_INC);

  // Direction changes only switch state; the count resumes from where it was.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OFF;
      cnt   <= '0;
    end else begin
      case (state)
        OFF: begin
          cnt <= '0;
          if (pwr_up)
            state <= RAMP_UP;
        end
        RAMP_UP: begin
          if (!pwr_up)
            state <= RAMP_DN;
          else if (cnt_up[27]) begin
            cnt   <= {8'hFF, 19'd0};
            state <= ON;
          end else
            cnt <= cnt_up[26:0];
        end
        ON: begin
          if (!pwr_up)
            state <= RAMP_DN;
        end
        RAMP_DN: begin
          if (pwr_up)
            state <= RAMP_UP;
          else if (cnt <= SS_STEP) begin
            cnt   <= '0;
            state <= OFF;
          end else
            cnt <= cnt - SS_STEP;
        end
        default: state <= OFF;
      endcase
    end
  end

  assign ss_tmr   = cnt[26:19];
  assign ss_state = state;

  assign unused_bits = ^{ptch_rt[D_SHIFT-1:0], prod[OUT_W+8], prod[7:0]};

endmodule

// File: tb/tb_pid_pipe_ctrl.sv
// tb/tb_pid_pipe_ctrl.sv - directed bench for pid_pipe_ctrl
module tb_pid_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld = 1'b0;
  logic        pwr_up = 1'b0;
  logic        rider_off = 1'b0;
  logic [15:0] ptch = '0;
  logic [15:0] ptch_rt = '0;
  logic [11:0] PID_cntrl;
  logic        out_vld;
  logic [7:0]  ss_tmr;
  logic [1:0]  ss_state;

  int total = 0;
  int bad = 0;

  pid_pipe_ctrl #(.SS_INC(1 << 19)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld       (vld),
    .ptch      (ptch),
    .ptch_rt   (ptch_rt),
    .pwr_up    (pwr_up),
    .rider_off (rider_off),
    .PID_cntrl (PID_cntrl),
    .out_vld   (out_vld),
    .ss_tmr    (ss_tmr),
    .ss_state  (ss_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int pid_exp(input int sum, input int ss);
    int s;
    s = (sum > 2047) ? 2047 : ((sum < -2048) ? -2048 : sum);
    return (s * ss) >>> 8;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] p, input logic [15:0] r);
    ptch = p;
    ptch_rt = r;
    vld = 1'b1;
    tick();
    vld = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int exp_pid);
    chk({tag, "_lat1"}, out_vld, 0);
    tick();
    chk({tag, "_lat2"}, out_vld, 0);
    tick();
    chk({tag, "_vld"}, out_vld, 1);
    chk({tag, "_pid"}, $signed(PID_cntrl), exp_pid);
    tick();
    chk({tag, "_pulse"}, out_vld, 0);
    chk({tag, "_hold"}, $signed(PID_cntrl), exp_pid);
  endtask

  task automatic clear_int();
    rider_off = 1'b1;
    tick();
    rider_off = 1'b0;
    chk("clear_int", dut.integ, 0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_pid", $signed(PID_cntrl), 0);
    chk("rst_vld", out_vld, 0);
    chk("rst_ss", {ss_state, ss_tmr}, 0);
    rst_n = 1'b1;

    pwr_up = 1'b1;
    tick();
    chk("ramp_start", {ss_state, ss_tmr}, 256 * 1 + 0);
    for (int k = 1; k <= 255; k++) begin
      tick();
      chk("ramp_up", {ss_state, ss_tmr}, 256 * 1 + k);
    end
    tick();
    chk("ramp_on", {ss_state, ss_tmr}, 256 * 2 + 255);
    tick();
    chk("on_hold", {ss_state, ss_tmr}, 256 * 2 + 255);

    send(16'h0010, 16'h0000);
    expect_out("p_small", 143);
    chk("int_16", dut.integ, 16);

    send(16'h0000, 16'h0000);
    expect_out("i_term", pid_exp(8, 255));

    clear_int();
    send(16'h7FFF, 16'h0000);
    expect_out("p_sat", 2039);
    chk("int_511", dut.integ, 511);

    clear_int();
    send(16'h0000, 16'h0400);
    expect_out("d_term", -16);

    clear_int();
    send(16'hFFEC, 16'h0000);
    expect_out("p_neg", -180);

    clear_int();
    send(16'h8000, 16'h0000);
    expect_out("p_negsat", -2040);

    clear_int();
    ptch = 16'h0010;
    ptch_rt = 16'h0000;
    vld = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("b2b_int", dut.integ, 16 * i);
      if (i >= 3) begin
        chk("b2b_vld", out_vld, 1);
        chk("b2b_pid", $signed(PID_cntrl), pid_exp(144 + 8 * (i - 3), 255));
      end
    end
    rider_off = 1'b1;
    tick();
    chk("rider_off_prio", dut.integ, 0);
    rider_off = 1'b0;
    vld = 1'b0;
    repeat (4) tick();

    clear_int();
    ptch = 16'h7FFF;
    vld = 1'b1;
    repeat (300) tick();
    vld = 1'b0;
    chk("int_nowrap", dut.integ, 130816);
    send(16'h8000, 16'h0000);
    chk("int_down", dut.integ, 130304);
    repeat (3) tick();

    pwr_up = 1'b0;
    tick();
    chk("dn_start", {ss_state, ss_tmr}, 256 * 3 + 255);
    repeat (5) tick();
    chk("dn_5", {ss_state, ss_tmr}, 256 * 3 + 250);
    pwr_up = 1'b1;
    tick();
    chk("dn_resume", {ss_state, ss_tmr}, 256 * 1 + 250);
    tick();
    chk("up_again", {ss_state, ss_tmr}, 256 * 1 + 251);
    pwr_up = 1'b0;
    tick();
    chk("dn_again", {ss_state, ss_tmr}, 256 * 3 + 251);
    for (int k = 1; k <= 250; k++) begin
      tick();
      chk("ramp_dn", {ss_state, ss_tmr}, 256 * 3 + 251 - k);
    end
    tick();
    chk("dn_off", {ss_state, ss_tmr}, 0);

    chk("pre_rst_pid", $signed(PID_cntrl), 2039);
    send(16'h0010, 16'h0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pid", $signed(PID_cntrl), 0);
    chk("async_vld", out_vld, 0);
    chk("async_int", dut.integ, 0);
    chk("async_ss", {ss_state, ss_tmr}, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_stale_vld", out_vld, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
